mips_muldiv: RTL

//  Multi-cycle multiply/divide unit with architectural HI/LO registers for the unpipelined MIPS core.

---
 rtl/mips_muldiv.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative multiply/divide unit holding the architectural HI/LO
// registers of the unpipelined MIPS core.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_start        op request, taken only while idle
//   i_op           000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   i_rs, i_rt     register-file read ports (operand A/dividend, operand B/divisor)
//   o_hi, o_lo     HI/LO registers
//   o_busy         high while a mul/div is in flight
//   o_done         one-cycle pulse when HI/LO were just written by a mul/div
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting; accepts mul/div starts and MTHI/MTLO
// ST_RUN   | DATA_W iterations, one result bit per cycle on magnitudes
// ST_FIX   | apply result signs, write HI/LO, pulse o_done

module mips_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_rs,
    input  logic [DATA_W-1:0] i_rt,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo,
    output logic              o_busy,
    output logic              o_done
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;     // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [DATA_W-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic                is_div_q, is_div_d;
    logic                neg_q, neg_d;     // product / quotient sign
    logic                rneg_q, rneg_d;   // remainder sign (sign of dividend)
    logic                dz_q, dz_d;       // divide by zero
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                done_q, done_d;

    logic                signed_op;
    logic                a_neg, b_neg;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_part;
    logic [DATA_W:0]     div_trial;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo, rem;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        signed_op = ~i_op[0];
        a_neg     = signed_op & i_rs[DATA_W-1];
        b_neg     = signed_op & i_rt[DATA_W-1];
        a_mag     = a_neg ? -i_rs : i_rs;
        b_mag     = b_neg ? -i_rt : i_rt;
        mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        // Partial remainder shifted left with the next dividend bit pulled in.
        div_part  = acc_q[2*DATA_W-1:DATA_W-1];
        div_trial = div_part - {1'b0, opnd_q};
        prod      = neg_q ? -acc_q : acc_q;
        quo       = neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
        rem       = rneg_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    case (i_op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            is_div_d = i_op[1];
                            neg_d    = a_neg ^ b_neg;
                            rneg_d   = a_neg;
                            dz_d     = i_op[1] && (i_rt == '0);
                            cnt_d    = '0;
                            state_d  = ST_RUN;
                            if (i_op[1]) begin
                                acc_d  = {{DATA_W{1'b0}}, a_mag};
                                opnd_d = b_mag;
                            end else begin
                                acc_d  = {{DATA_W{1'b0}}, b_mag};
                                opnd_d = a_mag;
                            end
                        end
                        3'b100:  hi_d = i_rs;
                        3'b101:  lo_d = i_rs;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (is_div_q) begin
                    if (div_part >= {1'b0, opnd_q}) begin
                        acc_d = {div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                    end else begin
                        acc_d = {div_part[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[DATA_W-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (is_div_q) begin
                    // Divisor 0 leaves the magnitude of the dividend as remainder;
                    // the remainder sign fix then restores the original i_rs.
                    lo_d = dz_q ? '1 : quo;
                    hi_d = rem;
                end else begin
                    hi_d = prod[2*DATA_W-1:DATA_W];
                    lo_d = prod[DATA_W-1:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign o_hi   = hi_q;
    assign o_lo   = lo_q;
    assign o_busy = (state_q != ST_IDLE);
    assign o_done = done_q;

endmodule
